// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared types, range codes and gate-length helper for the frequency meter
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        LOAD = 2'd2,
        CLR  = 2'd3
    } state_t;

    localparam logic [1:0] RANGE_DIV1    = 2'd0;
    localparam logic [1:0] RANGE_DIV10   = 2'd1;
    localparam logic [1:0] RANGE_DIV100  = 2'd2;
    localparam logic [1:0] RANGE_DIV1000 = 2'd3;

    // Gate length in clock cycles for a range code: base gate divided by 10^range.
    function automatic int unsigned gate_len(input int unsigned g, input logic [1:0] rng);
        case (rng)
            RANGE_DIV1:   gate_len = g;
            RANGE_DIV10:  gate_len = g / 10;
            RANGE_DIV100: gate_len = g / 100;
            default:      gate_len = g / 1000;
        endcase
    endfunction

endpackage

// File: rtl/fm_channel.sv
// rtl/fm_channel.sv - one measured input: synchroniser, edge detect, saturating counter, result latch
module fm_channel #(
    parameter int CW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_fsin,
    input  logic          i_cnt_en,
    input  logic          i_cnt_clr,
    input  logic          i_load,
    output logic [CW-1:0] o_result,
    output logic          o_ovf
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    // r_sync[0], r_sync[1] form the synchroniser; r_sync[2] holds the previous synchronised level
    logic [2:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_ovf_sticky;
    logic [CW-1:0] r_result;
    logic          r_ovf;
    logic          w_edge;

    assign w_edge   = r_sync[1] & ~r_sync[2];
    assign o_result = r_result;
    assign o_ovf    = r_ovf;

    // Bring the asynchronous input into the clock domain and keep one extra stage for edge detect
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[1:0], i_fsin};
        end
    end

    // Count edges while enabled; once saturated, further edges only raise the sticky overflow
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (i_cnt_clr) begin
            r_cnt        <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (i_cnt_en && w_edge) begin
            if (r_cnt == CNT_MAX) begin
                r_ovf_sticky <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Latch the finished window's count and overflow for the readout side
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else if (i_load) begin
            r_result <= r_cnt;
            r_ovf    <= r_ovf_sticky;
        end
    end

endmodule

// File: rtl/freq_meter_multi.sv
// rtl/freq_meter_multi.sv - multi-channel frequency meter: gate FSM, gate timer and result strobe
module freq_meter_multi
    import freq_meter_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter int          CW          = 32,
    parameter int unsigned GATE_CYCLES = 50_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NCH-1:0]    i_fsin,
    input  logic              i_run,
    input  logic [1:0]        i_range,
    output logic [NCH*CW-1:0] o_dout,
    output logic [NCH-1:0]    o_ovf,
    output logic              o_valid,
    output logic              o_busy
);

    localparam int TW = $clog2(GATE_CYCLES + 1);

    localparam logic [TW-1:0] G_DIV1    = TW'(gate_len(GATE_CYCLES, RANGE_DIV1));
    localparam logic [TW-1:0] G_DIV10   = TW'(gate_len(GATE_CYCLES, RANGE_DIV10));
    localparam logic [TW-1:0] G_DIV100  = TW'(gate_len(GATE_CYCLES, RANGE_DIV100));
    localparam logic [TW-1:0] G_DIV1000 = TW'(gate_len(GATE_CYCLES, RANGE_DIV1000));

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic [TW-1:0] w_gate_len;
    logic          r_valid;
    logic          w_cnt_en;
    logic          w_cnt_clr;
    logic          w_load;

    assign o_valid = r_valid;
    assign o_busy  = (r_state != IDLE);

    // Gate length for the currently presented range code; only consumed at gate start
    always_comb begin
        w_gate_len = G_DIV1000;
        case (i_range)
            RANGE_DIV1:   w_gate_len = G_DIV1;
            RANGE_DIV10:  w_gate_len = G_DIV10;
            RANGE_DIV100: w_gate_len = G_DIV100;
            default:      w_gate_len = G_DIV1000;
        endcase
    end

    // State, gate timer and result strobe registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_valid <= (r_state == LOAD);
        end
    end

    // Next state, timer reload/decrement and channel controls
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_cnt_en    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_clr = 1'b1;
                if (i_run) begin
                    w_state_nxt = GATE;
                    w_timer_nxt = w_gate_len;
                end
            end
            GATE: begin
                if (!i_run) begin
                    // Abort: drop the partial window, results stay as they were
                    w_state_nxt = IDLE;
                    w_timer_nxt = '0;
                    w_cnt_clr   = 1'b1;
                end else begin
                    w_cnt_en    = 1'b1;
                    w_timer_nxt = r_timer - 1'b1;
                    if (r_timer == TW'(1)) begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = CLR;
            end
            CLR: begin
                w_cnt_clr = 1'b1;
                if (i_run) begin
                    w_state_nxt = GATE;
                    w_timer_nxt = w_gate_len;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        fm_channel #(
            .CW(CW)
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_fsin    (i_fsin[k]),
            .i_cnt_en  (w_cnt_en),
            .i_cnt_clr (w_cnt_clr),
            .i_load    (w_load),
            .o_result  (o_dout[k*CW +: CW]),
            .o_ovf     (o_ovf[k])
        );
    end

endmodule

// File: tb/tb_freq_meter_multi.sv
// tb/tb_freq_meter_multi.sv - self-checking bench for freq_meter_multi
module tb_freq_meter_multi;

    localparam int          NCH  = 4;
    localparam int          CW   = 8;
    localparam int unsigned GC   = 1000;
    localparam int          MAXC = (1 << CW) - 1;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic              run   = 1'b0;
    logic [1:0]        range = 2'd0;
    logic [NCH-1:0]    fsin  = '0;
    logic [NCH*CW-1:0] dout;
    logic [NCH-1:0]    ovf;
    logic              valid;
    logic              busy;

    int n_chk  = 0;
    int n_fail = 0;

    freq_meter_multi #(
        .NCH         (NCH),
        .CW          (CW),
        .GATE_CYCLES (GC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_fsin  (fsin),
        .i_run   (run),
        .i_range (range),
        .o_dout  (dout),
        .o_ovf   (ovf),
        .o_valid (valid),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", nm, act, lo, hi, $time);
        end
    endtask

    function automatic int ch(input int k);
        return int'(dout[k*CW +: CW]);
    endfunction

    // Square-wave generators: per[k] = period in clocks, 0 = held low
    int per[NCH];
    int ph[NCH];
    always @(negedge clk) begin
        for (int k = 0; k < NCH; k++) begin
            if (per[k] == 0) begin
                fsin[k] = 1'b0;
                ph[k]   = 0;
            end else begin
                ph[k]   = (ph[k] + 1) % per[k];
                fsin[k] = (ph[k] < per[k] / 2);
            end
        end
    end

    // Reference model: windows tracked as cycle offsets from the edge that started them
    int                m_cnt[NCH];
    bit                m_ovf_st[NCH];
    bit                m_active;
    int                m_off;
    int                m_glen;
    logic [NCH-1:0]    h1, h2, h3, det;
    logic [NCH*CW-1:0] e_dout;
    logic [NCH-1:0]    e_ovf;
    bit                e_valid;

    function automatic int gate_of(input logic [1:0] r);
        int g = int'(GC);
        for (int i = 0; i < int'(r); i++) g = g / 10;
        return g;
    endfunction

    task automatic start_win();
        m_active = 1'b1;
        m_off    = 0;
        m_glen   = gate_of(range);
        for (int k = 0; k < NCH; k++) begin
            m_cnt[k]    = 0;
            m_ovf_st[k] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_off    = 0;
            m_glen   = 0;
            h1 = '0; h2 = '0; h3 = '0; det = '0;
            e_dout  = '0;
            e_ovf   = '0;
            e_valid = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                m_cnt[k]    = 0;
                m_ovf_st[k] = 1'b0;
            end
        end else begin
            // pin level two clocks ago rising above the level three clocks ago
            det = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = fsin;
            e_valid = 1'b0;
            if (!m_active) begin
                if (run) start_win();
            end else begin
                m_off++;
                if (m_off <= m_glen) begin
                    if (!run) begin
                        m_active = 1'b0;
                    end else begin
                        for (int k = 0; k < NCH; k++) begin
                            if (det[k]) begin
                                if (m_cnt[k] == MAXC) m_ovf_st[k] = 1'b1;
                                else m_cnt[k] = m_cnt[k] + 1;
                            end
                        end
                    end
                end else if (m_off == m_glen + 1) begin
                    for (int k = 0; k < NCH; k++) begin
                        e_dout[k*CW +: CW] = CW'(m_cnt[k]);
                        e_ovf[k]           = m_ovf_st[k];
                    end
                    e_valid = 1'b1;
                end else begin
                    if (run) start_win();
                    else m_active = 1'b0;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_valid", 64'(valid), 64'(e_valid));
            chk("model_busy",  64'(busy),  64'(m_active));
            chk("model_dout",  64'(dout),  64'(e_dout));
            chk("model_ovf",   64'(ovf),   64'(e_ovf));
        end
    end

    task automatic wait_valid(input string nm, input int exp_lat);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid && n < 3000);
        chk(nm, 64'(n), 64'(exp_lat));
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_dout",  64'(dout),  64'd0);
        chk("rst_ovf",   64'(ovf),   64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_busy",  64'(busy),  64'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // basic: 10-clock period on channel 0, full gate
        per[0] = 10; range = 2'd0;
        repeat (5) @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_valid("t1_latency", 1001);
        chk_rng("t1_ch0", ch(0), 99, 101);
        chk("t1_ovf", 64'(ovf), 64'd0);
        run = 1'b0;
        repeat (3) @(negedge clk);

        // range 1: gate of 100 clocks; a range change mid-gate must not alter the window
        range = 2'd1;
        run   = 1'b1;
        wait_valid("t2_latency", 102);
        chk_rng("t2_ch0_a", ch(0), 9, 11);
        repeat (50) @(negedge clk);
        range = 2'd3;
        wait_valid("t2_period", 52);
        chk_rng("t2_ch0_b", ch(0), 9, 11);
        run   = 1'b0;
        range = 2'd0;
        repeat (3) @(negedge clk);

        // independent channels
        per[0] = 4; per[1] = 10; per[2] = 20; per[3] = 0;
        run = 1'b1;
        wait_valid("t3_latency", 1002);
        chk_rng("t3_ch0", ch(0), 249, 251);
        chk_rng("t3_ch1", ch(1), 99, 101);
        chk_rng("t3_ch2", ch(2), 49, 51);
        chk("t3_ch3", 64'(ch(3)), 64'd0);
        chk("t3_ovf", 64'(ovf), 64'd0);
        run = 1'b0;
        repeat (3) @(negedge clk);

        // abort at gate cycle 500: no strobe, results keep the previous window
        run = 1'b1;
        repeat (500) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid) seen++;
        end
        chk("t5_no_valid", 64'(seen), 64'd0);
        chk_rng("t5_ch0_kept", ch(0), 249, 251);
        chk_rng("t5_ch1_kept", ch(1), 99, 101);

        // overflow on channel 1, then a clean window clears it
        per[0] = 0; per[1] = 2; per[2] = 0; per[3] = 0;
        run = 1'b1;
        wait_valid("t4_latency", 1002);
        chk("t4_ch1_sat", 64'(ch(1)), 64'd255);
        chk("t4_ovf", 64'(ovf), 64'b0010);
        chk("t4_ch0", 64'(ch(0)), 64'd0);
        run    = 1'b0;
        per[1] = 0;
        repeat (5) @(negedge clk);
        run = 1'b1;
        wait_valid("t4b_latency", 1002);
        chk("t4b_ch1", 64'(ch(1)), 64'd0);
        chk("t4b_ovf", 64'(ovf), 64'd0);
        run = 1'b0;
        repeat (3) @(negedge clk);

        // asynchronous reset in the middle of a gate, then a clean restart
        per[0] = 10;
        run = 1'b1;
        repeat (300) @(negedge clk);
        chk_rng("t6_pre_ch0", ch(0), 0, 0);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_dout",  64'(dout),  64'd0);
        chk("t6_ovf",   64'(ovf),   64'd0);
        chk("t6_valid", 64'(valid), 64'd0);
        chk("t6_busy",  64'(busy),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("t6_latency", 1002);
        chk_rng("t6_ch0", ch(0), 99, 101);
        chk("t6_ovf_after", 64'(ovf), 64'd0);
        run = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
